beat_sequencer: RTL and testbench

BEAT_SEQUENCER -- requirements
Module: beat_sequencer

---
 rtl/beat_seq_pkg.sv | 25 ++
 rtl/sw_edge_latch.sv | 52 +++++
 rtl/beat_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_beat_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/beat_seq_pkg.sv
// Shared definitions for the beat sequencer rhythm game.
// Holds the FSM state encoding, lane/score/miss widths and a saturating score adder.
package beat_seq_pkg;

  localparam int unsigned LANES   = 4;
  localparam int unsigned SCORE_W = 8;
  localparam int unsigned MISS_W  = 4;
  localparam int unsigned ADDR_W  = 6;

  typedef enum logic [1:0] {
    StIdle,
    StCntdn,
    StPlay,
    StOver
  } state_e;

  // Adds inc to a, clamping at the all-ones score.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [1:0]         inc);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + {{(SCORE_W - 1){1'b0}}, inc};
    return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/sw_edge_latch.sv
// Player input capture for the beat sequencer.
// Keeps a one-cycle history of the lane switches, detects rising edges and
// accumulates them into hit_mask while playing.
// Ports:
//   board_clk  clock
//   rst_btn    asynchronous active-high reset
//   sw         synchronised lane switches
//   play       high while the game is in PLAY
//   beat_tick  beat pulse; on a PLAY tick the mask restarts from this cycle's edges
//   clear      clears the mask when a new game is accepted
//   hit_mask   registered lanes pressed during the current step
module sw_edge_latch
  import beat_seq_pkg::*;
(
  input  logic             board_clk,
  input  logic             rst_btn,
  input  logic [LANES-1:0] sw,
  input  logic             play,
  input  logic             beat_tick,
  input  logic             clear,
  output logic [LANES-1:0] hit_mask
);

  logic [LANES-1:0] sw_q;
  logic [LANES-1:0] hit_mask_q, hit_mask_d;
  logic [LANES-1:0] edges;

  assign edges = sw & ~sw_q;

  always_comb begin
    hit_mask_d = hit_mask_q;
    if (clear) begin
      hit_mask_d = '0;
    end else if (play) begin
      // A press landing on the tick belongs to the step that starts now.
      hit_mask_d = beat_tick ? edges : (hit_mask_q | edges);
    end
  end

  always_ff @(posedge board_clk or posedge rst_btn) begin
    if (rst_btn) begin
      sw_q       <= '0;
      hit_mask_q <= '0;
    end else begin
      sw_q       <= sw;
      hit_mask_q <= hit_mask_d;
    end
  end

  assign hit_mask = hit_mask_q;

endmodule

// File: rtl/beat_sequencer.sv
// Beat sequencer rhythm game: counts down, then steps through a lane pattern ROM
// on each beat, judging player presses as hits or misses until the pattern ends
// or too many misses accumulate.
// Optional feature macro: BEAT_SEQ_STREAK_EN -- hits made while four or more
// consecutive hits precede them score 2 instead of 1.
// Ports:
//   board_clk  clock;  rst_btn  asynchronous active-high reset
//   start      request to begin a game (IDLE/OVER only)
//   beat_tick  beat pulse
//   sw         synchronised lane switches
//   pat_addr   pattern ROM address;  pat_data  ROM lane mask (same-cycle read)
//   led        {hit_mask, target}
//   score      saturating hit score;  miss_cnt  misses this game
//   game       high in PLAY;  done  high in OVER
module beat_sequencer
  import beat_seq_pkg::*;
#(
  parameter int unsigned STEPS    = 32,
  parameter int unsigned MAX_MISS = 8,
  parameter int unsigned CD_BEATS = 3
) (
  input  logic                 board_clk,
  input  logic                 rst_btn,
  input  logic                 start,
  input  logic                 beat_tick,
  input  logic [LANES-1:0]     sw,
  output logic [ADDR_W-1:0]    pat_addr,
  input  logic [LANES-1:0]     pat_data,
  output logic [2*LANES-1:0]   led,
  output logic [SCORE_W-1:0]   score,
  output logic [MISS_W-1:0]    miss_cnt,
  output logic                 game,
  output logic                 done
);

  localparam logic [ADDR_W-1:0] LastStep = ADDR_W'(STEPS - 1);
  localparam logic [MISS_W-1:0] MissLim  = MISS_W'(MAX_MISS);
  localparam logic [2:0]        CdInit   = 3'(CD_BEATS);

  state_e               state_q, state_d;
  logic [2:0]           cd_cnt_q, cd_cnt_d;
  logic [ADDR_W-1:0]    pat_addr_q, pat_addr_d;
  logic [ADDR_W-1:0]    step_q, step_d;  // index of the step held in target
  logic [LANES-1:0]     target_q, target_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [MISS_W-1:0]    miss_q, miss_d;
  logic                 game_q, game_d;
  logic                 done_q, done_d;
`ifdef BEAT_SEQ_STREAK_EN
  logic [3:0]           streak_q, streak_d;
`endif

  logic                 start_acc;
  logic                 hit, miss;
  logic [1:0]           score_inc;
  logic [LANES-1:0]     hit_mask;

  sw_edge_latch u_sw_edge_latch (
    .board_clk (board_clk),
    .rst_btn   (rst_btn),
    .sw        (sw),
    .play      (state_q == StPlay),
    .beat_tick (beat_tick),
    .clear     (start_acc),
    .hit_mask  (hit_mask)
  );

  always_comb begin
    state_d    = state_q;
    cd_cnt_d   = cd_cnt_q;
    pat_addr_d = pat_addr_q;
    step_d     = step_q;
    target_d   = target_q;
    score_d    = score_q;
    miss_d     = miss_q;
    start_acc  = 1'b0;
`ifdef BEAT_SEQ_STREAK_EN
    streak_d   = streak_q;
`endif

    hit  = (target_q != '0) && (hit_mask == target_q);
    miss = !hit && ((target_q != '0) || (hit_mask != '0));

    score_inc = 2'd1;
`ifdef BEAT_SEQ_STREAK_EN
    if (streak_q >= 4'd4) score_inc = 2'd2;
`endif

    unique case (state_q)
      StIdle, StOver: begin
        // start wins over a coincident beat_tick; ticks are otherwise ignored here.
        if (start) begin
          start_acc  = 1'b1;
          state_d    = StCntdn;
          cd_cnt_d   = CdInit;
          pat_addr_d = '0;
          step_d     = '0;
          score_d    = '0;
          miss_d     = '0;
`ifdef BEAT_SEQ_STREAK_EN
          streak_d   = '0;
`endif
        end
      end
      StCntdn: begin
        if (beat_tick) begin
          cd_cnt_d = cd_cnt_q - 3'd1;
          if (cd_cnt_q == 3'd1) begin
            state_d    = StPlay;
            target_d   = pat_data;
            pat_addr_d = ADDR_W'(1);
            step_d     = '0;
          end
        end
      end
      StPlay: begin
        if (beat_tick) begin
          if (hit) begin
            score_d = sat_add(score_q, score_inc);
`ifdef BEAT_SEQ_STREAK_EN
            if (streak_q != 4'hF) streak_d = streak_q + 4'd1;
`endif
          end
          if (miss) begin
            miss_d = miss_q + 1'b1;
`ifdef BEAT_SEQ_STREAK_EN
            streak_d = '0;
`endif
          end
          target_d = pat_data;
          if (pat_addr_q != LastStep) pat_addr_d = pat_addr_q + 1'b1;
          if ((miss && (miss_d == MissLim)) || (step_q == LastStep)) begin
            state_d = StOver;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    game_d = (state_d == StPlay);
    done_d = (state_d == StOver);
  end

  always_ff @(posedge board_clk or posedge rst_btn) begin
    if (rst_btn) begin
      state_q    <= StIdle;
      cd_cnt_q   <= '0;
      pat_addr_q <= '0;
      step_q     <= '0;
      target_q   <= '0;
      score_q    <= '0;
      miss_q     <= '0;
      game_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef BEAT_SEQ_STREAK_EN
      streak_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cd_cnt_q   <= cd_cnt_d;
      pat_addr_q <= pat_addr_d;
      step_q     <= step_d;
      target_q   <= target_d;
      score_q    <= score_d;
      miss_q     <= miss_d;
      game_q     <= game_d;
      done_q     <= done_d;
`ifdef BEAT_SEQ_STREAK_EN
      streak_q   <= streak_d;
`endif
    end
  end

  assign pat_addr = pat_addr_q;
  assign led      = {hit_mask, target_q};
  assign score    = score_q;
  assign miss_cnt = miss_q;
  assign game     = game_q;
  assign done     = done_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// Self-checking bench for beat_sequencer: vector tables feed a scoreboard queue,
// plus hand-written sequences for edge seeding, countdown and mid-game reset.
module tb_beat_sequencer;

`ifdef BEAT_SEQ_STREAK_EN
  localparam bit Streak = 1'b1;
`else
  localparam bit Streak = 1'b0;
`endif

  logic       board_clk = 1'b0;
  logic       rst_btn   = 1'b0;
  logic       start     = 1'b0;
  logic       beat_tick = 1'b0;
  logic [3:0] sw        = 4'h0;
  logic [5:0] pat_addr;
  logic [3:0] pat_data;
  logic [7:0] led;
  logic [7:0] score;
  logic [3:0] miss_cnt;
  logic       game;
  logic       done;

  logic [3:0] rom [64];
  assign pat_data = rom[pat_addr];

  always #5 board_clk = ~board_clk;

  beat_sequencer dut (
    .board_clk (board_clk),
    .rst_btn   (rst_btn),
    .start     (start),
    .beat_tick (beat_tick),
    .sw        (sw),
    .pat_addr  (pat_addr),
    .pat_data  (pat_data),
    .led       (led),
    .score     (score),
    .miss_cnt  (miss_cnt),
    .game      (game),
    .done      (done)
  );

  typedef struct {
    logic [3:0] press;
    int         score;
    int         miss;
    int         addr;
    logic       game;
    logic       done;
  } vec_t;

  vec_t exp_q[$];
  vec_t tab_a[12];
  vec_t tab_b[33];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge board_clk);
    #1;
  endtask

  task automatic press(input logic [3:0] m);
    sw = m;
    step();
    sw = 4'h0;
    step();
  endtask

  task automatic tick();
    beat_tick = 1'b1;
    step();
    beat_tick = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    press(v.press);
    exp_q.push_back(v);
    tick();
  endtask

  task automatic check_out(input string tag);
    vec_t e;
    if (exp_q.size() == 0) begin
      chk({tag, " scoreboard empty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, " score"}, int'(score), e.score);
      chk({tag, " miss_cnt"}, int'(miss_cnt), e.miss);
      chk({tag, " pat_addr"}, int'(pat_addr), e.addr);
      chk({tag, " game"}, int'(game), int'(e.game));
      chk({tag, " done"}, int'(done), int'(e.done));
    end
  endtask

  function automatic int streak_score(input int hits);
    int s = 0;
    for (int j = 0; j < hits; j++) s += (Streak && j >= 4) ? 2 : 1;
    return s;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, " score"}, int'(score), 0);
    chk({tag, " miss_cnt"}, int'(miss_cnt), 0);
    chk({tag, " pat_addr"}, int'(pat_addr), 0);
    chk({tag, " led"}, int'(led), 0);
    chk({tag, " game"}, int'(game), 0);
    chk({tag, " done"}, int'(done), 0);
  endtask

  initial begin
    // Game A pattern: step 0 two lanes, steps 1-2 rests, then nonzero targets.
    for (int i = 0; i < 64; i++) rom[i] = 4'((i % 15) + 1);
    rom[0] = 4'h5;
    rom[1] = 4'h0;
    rom[2] = 4'h0;

    tab_a[0] = '{4'h5, 1, 0, 2, 1'b1, 1'b0};
    tab_a[1] = '{4'h8, 1, 1, 3, 1'b1, 1'b0};
    tab_a[2] = '{4'h0, 1, 1, 4, 1'b1, 1'b0};
    for (int k = 3; k < 10; k++) begin
      tab_a[k] = '{rom[k] ^ 4'hF, 1, k - 1, k + 2, (k != 9), (k == 9)};
    end
    tab_a[10] = '{4'h5, 1, 8, 11, 1'b0, 1'b1};
    tab_a[11] = '{4'h0, 1, 8, 11, 1'b0, 1'b1};

    // Reset state, asserted asynchronously before any clock edge.
    #1 rst_btn = 1'b1;
    #1 check_zero("reset");
    step();
    step();
    rst_btn = 1'b0;

    // start and beat_tick together: start only, countdown still needs 3 ticks.
    start     = 1'b1;
    beat_tick = 1'b1;
    step();
    start     = 1'b0;
    beat_tick = 1'b0;
    chk("cntdn game after start", int'(game), 0);
    tick();
    tick();
    chk("cntdn game after 2 ticks", int'(game), 0);
    tick();
    chk("play game after 3 ticks", int'(game), 1);
    chk("play target rom0", int'(led[3:0]), 5);
    chk("play pat_addr", int'(pat_addr), 1);
    chk("play hit_mask", int'(led[7:4]), 0);

    for (int i = 0; i < 12; i++) begin
      if (i == 3) do_start();  // ignored mid-game
      drive(tab_a[i]);
      check_out($sformatf("A%0d", i));
    end

    // Game B: every step nonzero and hit, started from OVER.
    rom[0] = 4'h1;
    rom[1] = 4'h2;
    rom[2] = 4'h3;
    for (int k = 0; k < 32; k++) begin
      tab_b[k] = '{rom[k], streak_score(k + 1), 0, (k + 2 > 31) ? 31 : k + 2,
                   (k != 31), (k == 31)};
    end
    tab_b[32] = '{4'h1, streak_score(32), 0, 31, 1'b0, 1'b1};
    do_start();
    chk("B cleared score", int'(score), 0);
    chk("B cleared miss", int'(miss_cnt), 0);
    tick();
    tick();
    tick();
    chk("B target rom0", int'(led[3:0]), 1);
    for (int k = 0; k < 33; k++) begin
      drive(tab_b[k]);
      check_out($sformatf("B%0d", k));
    end

    // Game C: an edge on a tick cycle seeds the next step's mask.
    do_start();
    tick();
    tick();
    tick();
    press(4'h1);
    tick();
    chk("C0 score", int'(score), 1);
    sw        = 4'h2;
    beat_tick = 1'b1;
    step();
    beat_tick = 1'b0;
    sw        = 4'h0;
    step();
    chk("C1 miss", int'(miss_cnt), 1);
    chk("C1 seeded mask", int'(led[7:4]), 2);
    press(4'h1);
    tick();
    chk("C2 score", int'(score), 2);
    chk("C2 miss", int'(miss_cnt), 1);
    for (int k = 3; k < 10; k++) begin
      press(rom[k]);
      tick();
    end
    chk("C9 score", int'(score), Streak ? 13 : 9);
    chk("C9 pat_addr", int'(pat_addr), 11);

    // Asynchronous reset at step 10, checked before the next clock edge.
    #2 rst_btn = 1'b1;
    #1 check_zero("midgame reset");
    step();
    rst_btn = 1'b0;
    rom[0] = 4'h9;
    do_start();
    tick();
    tick();
    tick();
    chk("restart game", int'(game), 1);
    chk("restart target rom0", int'(led[3:0]), 9);
    chk("restart pat_addr", int'(pat_addr), 1);
    chk("restart score", int'(score), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
